// File: rtl/rally_sequencer.sv
// rtl/rally_sequencer.sv - match-level serve/rally/miss/game-over sequencer for the ball-motion controller
module rally_sequencer #(
    parameter int SERVE_FRAMES = 120,
    parameter int MISS_FRAMES  = 60,
    parameter int LIVES        = 3,
    parameter int MISS_X       = 620
) (
    input  logic       clk_25MHZ,
    input  logic       reset_n,
    input  logic       start_btn,
    input  logic       frame_tick,
    input  logic [9:0] ball_x,
    input  logic       is_ball_moving_left,
    input  logic       collision_detected,
    output logic       ball_rst,
    output logic       game_start,
    output logic [7:0] score,
    output logic [7:0] high_score,
    output logic [7:0] rally_count,
    output logic [1:0] lives,
    output logic [7:0] countdown,
    output logic       game_over,
    output logic [2:0] state_out
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SERVE     = 3'd1;
    localparam logic [2:0] S_RALLY     = 3'd2;
    localparam logic [2:0] S_MISS      = 3'd3;
    localparam logic [2:0] S_GAME_OVER = 3'd4;

    localparam logic [7:0] SERVE_N   = 8'(SERVE_FRAMES);
    localparam logic [7:0] SERVE_END = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] MISS_END  = 8'(MISS_FRAMES - 1);
    localparam logic [1:0] LIVES_N   = 2'(LIVES);
    localparam logic [9:0] MISS_XV   = 10'(MISS_X);

    logic [2:0] r_state;
    logic [7:0] r_frame_cnt;
    logic       r_start_d;
    logic       r_coll_d;
    logic       r_ball_rst;
    logic       r_game_start;
    logic [7:0] r_score;
    logic [7:0] r_high_score;
    logic [7:0] r_rally_count;
    logic [1:0] r_lives;
    logic [7:0] r_countdown;
    logic       r_game_over;

    logic       w_start_edge;
    logic       w_hit_edge;
    logic       w_miss;
    logic [7:0] w_score_inc;
    logic [7:0] w_rally_inc;

    // Edge detectors and saturating increments; a rise while the ball heads left is a bounce-back artefact, not a hit
    assign w_start_edge = start_btn & ~r_start_d;
    assign w_hit_edge   = collision_detected & ~r_coll_d & ~is_ball_moving_left;
    assign w_miss       = (ball_x >= MISS_XV) & ~is_ball_moving_left;
    assign w_score_inc  = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
    assign w_rally_inc  = (r_rally_count == 8'hFF) ? r_rally_count : r_rally_count + 8'd1;

    // Match state machine; ball_rst/game_start default low so each is a single-cycle pulse
    always_ff @(posedge clk_25MHZ) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_frame_cnt   <= 8'd0;
            r_start_d     <= 1'b0;
            r_coll_d      <= 1'b0;
            r_ball_rst    <= 1'b1;
            r_game_start  <= 1'b0;
            r_score       <= 8'd0;
            r_high_score  <= 8'd0;
            r_rally_count <= 8'd0;
            r_lives       <= LIVES_N;
            r_countdown   <= 8'd0;
            r_game_over   <= 1'b0;
        end else begin
            r_start_d    <= start_btn;
            r_coll_d     <= collision_detected;
            r_ball_rst   <= 1'b0;
            r_game_start <= 1'b0;
            case (r_state)
                S_IDLE, S_GAME_OVER: begin
                    // Score is frozen in GAME_OVER, so comparing every cycle equals a first-cycle update
                    if (r_state == S_GAME_OVER && r_score > r_high_score) begin
                        r_high_score <= r_score;
                    end
                    if (w_start_edge) begin
                        r_state       <= S_SERVE;
                        r_ball_rst    <= 1'b1;
                        r_score       <= 8'd0;
                        r_rally_count <= 8'd0;
                        r_frame_cnt   <= 8'd0;
                        r_lives       <= LIVES_N;
                        r_countdown   <= SERVE_N;
                        r_game_over   <= 1'b0;
                    end
                end
                S_SERVE: begin
                    if (frame_tick) begin
                        if (r_frame_cnt == SERVE_END) begin
                            r_state      <= S_RALLY;
                            r_game_start <= 1'b1;
                            r_frame_cnt  <= 8'd0;
                            r_countdown  <= 8'd0;
                        end else begin
                            r_frame_cnt <= r_frame_cnt + 8'd1;
                            r_countdown <= SERVE_N - r_frame_cnt - 8'd1;
                        end
                    end
                end
                S_RALLY: begin
                    // A miss in the same cycle as a hit edge takes priority and the hit is dropped
                    if (w_miss) begin
                        r_frame_cnt <= 8'd0;
                        if (r_lives > 2'd1) begin
                            r_lives       <= r_lives - 2'd1;
                            r_state       <= S_MISS;
                            r_ball_rst    <= 1'b1;
                            r_rally_count <= 8'd0;
                        end else begin
                            r_lives     <= 2'd0;
                            r_state     <= S_GAME_OVER;
                            r_game_over <= 1'b1;
                        end
                    end else if (w_hit_edge) begin
                        r_score       <= w_score_inc;
                        r_rally_count <= w_rally_inc;
                    end
                end
                S_MISS: begin
                    if (frame_tick) begin
                        if (r_frame_cnt == MISS_END) begin
                            r_state     <= S_SERVE;
                            r_frame_cnt <= 8'd0;
                            r_countdown <= SERVE_N;
                        end else begin
                            r_frame_cnt <= r_frame_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ball_rst    = r_ball_rst;
    assign game_start  = r_game_start;
    assign score       = r_score;
    assign high_score  = r_high_score;
    assign rally_count = r_rally_count;
    assign lives       = r_lives;
    assign countdown   = r_countdown;
    assign game_over   = r_game_over;
    assign state_out   = r_state;

endmodule
